// File: rtl/hdmi_audio_arb.sv
// Two-requester round-robin audio sample arbiter feeding a small FIFO that is drained at the audio rate.
// Optional macro HDMI_AUDIO_UNDERRUN_CNT_EN builds the saturating underrun counter.
module hdmi_audio_arb #(
  parameter int PIXEL_CLOCK = 40000000,
  parameter int AUDIO_RATE  = 48000,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_l,
  input  logic [15:0] req0_r,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_l,
  input  logic [15:0] req1_r,
  output logic        req1_ready,
  output logic [15:0] audio0,
  output logic [15:0] audio1,
  output logic        sample_stb,
  output logic [7:0]  underrun_cnt
);

  localparam int DIV = PIXEL_CLOCK / AUDIO_RATE;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] div_r;
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic          last_grant_r;
  logic [31:0]   mem_r [DEPTH];
  logic [15:0]   audio0_r;
  logic [15:0]   audio1_r;
  logic          sample_stb_r;

  logic          tick_s;
  logic          full_s;
  logic          empty_s;
  logic          ready0_s;
  logic          ready1_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   wdata_s;

  // Tick decode, FIFO status and round-robin grant.
  always_comb begin
    tick_s   = (div_r == DIV_MAX);
    full_s   = (count_r == FULL_CNT);
    empty_s  = (count_r == {CW{1'b0}});
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    wdata_s  = 32'd0;
    if (!reset && req0_valid && !full_s && (!req1_valid || last_grant_r != 1'b0)) begin
      ready0_s = 1'b1;
    end else begin
      ready0_s = 1'b0;
    end
    if (!reset && req1_valid && !full_s && (!req0_valid || last_grant_r != 1'b1)) begin
      ready1_s = 1'b1;
    end else begin
      ready1_s = 1'b0;
    end
    if (ready0_s) begin
      wdata_s = {req0_l, req0_r};
    end else if (ready1_s) begin
      wdata_s = {req1_l, req1_r};
    end else begin
      wdata_s = 32'd0;
    end
    push_s = ready0_s | ready1_s;
    pop_s  = tick_s & ~empty_s;
  end

  // Audio-rate divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= {DW{1'b0}};
    end else if (tick_s) begin
      div_r <= {DW{1'b0}};
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= wdata_s;
    end
  end

  // Pointers, occupancy and grant history.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r       <= {AW{1'b0}};
      rptr_r       <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      last_grant_r <= 1'b1;
    end else begin
      if (push_s) begin
        wptr_r       <= wptr_r + AW'(1);
        last_grant_r <= ready1_s;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output sample register and strobe; an underrun keeps the previous word.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio0_r     <= 16'd0;
      audio1_r     <= 16'd0;
      sample_stb_r <= 1'b0;
    end else begin
      sample_stb_r <= tick_s;
      if (pop_s) begin
        audio0_r <= mem_r[rptr_r][31:16];
        audio1_r <= mem_r[rptr_r][15:0];
      end
    end
  end

`ifdef HDMI_AUDIO_UNDERRUN_CNT_EN
  logic [7:0] underrun_r;

  // Saturating count of ticks that found the FIFO empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_r <= 8'd0;
    end else if (tick_s && empty_s && underrun_r != 8'hFF) begin
      underrun_r <= underrun_r + 8'd1;
    end
  end

  assign underrun_cnt = underrun_r;
`else
  assign underrun_cnt = 8'd0;
`endif

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign audio0     = audio0_r;
  assign audio1     = audio1_r;
  assign sample_stb = sample_stb_r;

endmodule

// File: tb/tb_hdmi_audio_arb.sv
// Randomized scoreboard bench for hdmi_audio_arb with a queue-based reference model.
module tb_hdmi_audio_arb;

  localparam int PCLK  = 480000;
  localparam int ARATE = 48000;
  localparam int DEPTH = 4;
  localparam int DIV   = PCLK / ARATE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_l = 16'd0, req0_r = 16'd0, req1_l = 16'd0, req1_r = 16'd0;
  logic        req0_ready, req1_ready, sample_stb;
  logic [15:0] audio0, audio1;
  logic [7:0]  underrun_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] aud;
    logic [7:0]  und;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  int          m_div = 0;
  bit          m_lg = 1'b1;
  logic [31:0] m_aud = 32'd0;
  int          m_und = 0;
  bit          prev_reset = 1'b0;

  hdmi_audio_arb #(.PIXEL_CLOCK(PCLK), .AUDIO_RATE(ARATE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_l(req0_l), .req0_r(req0_r), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_l(req1_l), .req1_r(req1_r), .req1_ready(req1_ready),
    .audio0(audio0), .audio1(audio1), .sample_stb(sample_stb), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] und_exp(input int n);
`ifdef HDMI_AUDIO_UNDERRUN_CNT_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  // Reference model: evaluates each cycle just before the rising edge that commits it.
  always @(negedge clk) begin : model
    bit e0, e1, full, tk;
    if (reset) begin
      check("ready0_reset", {31'd0, req0_ready}, 32'd0);
      check("ready1_reset", {31'd0, req1_ready}, 32'd0);
      if (prev_reset) begin
        check("audio0_reset", {16'd0, audio0}, 32'd0);
        check("audio1_reset", {16'd0, audio1}, 32'd0);
        check("stb_reset", {31'd0, sample_stb}, 32'd0);
        check("underrun_reset", {24'd0, underrun_cnt}, 32'd0);
      end
      mq.delete();
      m_lg = 1'b1; m_div = 0; m_aud = 32'd0; m_und = 0;
    end else begin
      full = (mq.size() == DEPTH);
      e0 = req0_valid && !full && (!req1_valid || m_lg != 1'b0);
      e1 = req1_valid && !full && (!req0_valid || m_lg != 1'b1);
      check("ready0", {31'd0, req0_ready}, {31'd0, e0});
      check("ready1", {31'd0, req1_ready}, {31'd0, e1});
      tk = (m_div == DIV - 1);
      if (tk) begin
        if (mq.size() > 0) m_aud = mq.pop_front();
        else if (m_und < 255) m_und++;
        exp_q.push_back('{aud: m_aud, und: und_exp(m_und)});
      end
      if (e0) begin mq.push_back({req0_l, req0_r}); m_lg = 1'b0; end
      else if (e1) begin mq.push_back({req1_l, req1_r}); m_lg = 1'b1; end
      m_div = tk ? 0 : m_div + 1;
    end
    prev_reset = reset;
  end

  // Monitor: every strobe consumes one expected sample.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sample_stb) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL stb_unexpected: got strobe expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("audio0", {16'd0, audio0}, {16'd0, e.aud[31:16]});
        check("audio1", {16'd0, audio1}, {16'd0, e.aud[15:0]});
        check("underrun_cnt", {24'd0, underrun_cnt}, {24'd0, e.und});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    req0_l = 16'($urandom); req0_r = 16'($urandom);
    req1_l = 16'($urandom); req1_r = 16'($urandom);
  endtask

  initial begin
    bit found;
    step(3);
    reset = 1'b0;

    // single push, output at first tick
    req0_valid = 1'b1; req0_l = 16'h1234; req0_r = 16'hABCD;
    step(1);
    req0_valid = 1'b0;
    step(25);

    // both requesters held: alternation, full FIFO back-pressure
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (40) begin rand_data(); step(1); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(60);

    // random traffic
    repeat (600) begin
      rand_data();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = ($urandom_range(0, 3) == 0);
      step(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(60);

    // one sample then long underrun run to saturation
    req0_valid = 1'b1; req0_l = 16'h0100; req0_r = 16'h0200;
    step(1);
    req0_valid = 1'b0;
    step(DIV * 305);

    // push into empty FIFO in the tick cycle
    found = 1'b0;
    for (int i = 0; i < 2 * DIV && !found; i++) begin
      if (m_div == DIV - 1) found = 1'b1;
      else step(1);
    end
    if (!found) begin
      total++;
      $display("FAIL tick_align: got no tick expected one within %0d cycles", 2 * DIV);
    end
    req1_valid = 1'b1; req1_l = 16'h5555; req1_r = 16'h6666;
    step(1);
    req1_valid = 1'b0;
    step(3 * DIV);

    // queue three entries then reset mid-operation
    req0_valid = 1'b1;
    repeat (3) begin rand_data(); step(1); end
    req0_valid = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(4 * DIV);

    step(5);
    check("exp_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hdmi_audio_arb.md
HDMI_AUDIO_ARB -- requirements
Module: hdmi_audio_arb

Interface
REQ-001 Parameter PIXEL_CLOCK, default 40000000, clk frequency in Hz.
REQ-002 Parameter AUDIO_RATE, default 48000, output sample rate in Hz.
REQ-003 Parameter DEPTH, default 4, sample FIFO depth in stereo words (power of 2, >=2).
REQ-004 clk  input  1  pixel clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0_valid  input  1  requester 0 (sound chip) offers a stereo sample.
REQ-007 req0_l, req0_r  input  16 each  requester 0 left/right sample, signed.
REQ-008 req0_ready  output  1  requester 0 sample is accepted this cycle.
REQ-009 req1_valid, req1_l, req1_r, req1_ready  same as REQ-006..008  requester 1 (beeper/digital).
REQ-010 audio0, audio1  output  16 each  current left/right sample word for the HDMI encoder.
REQ-011 sample_stb  output  1  one-cycle pulse when audio0/audio1 update.
REQ-012 underrun_cnt  output  8  count of ticks that found the FIFO empty.

Function
REQ-013 Tick divider: counter counts 0..PIXEL_CLOCK/AUDIO_RATE-1 (0..832 at defaults), then wraps to 0; the internal tick is asserted in the cycle the counter equals its maximum.
REQ-014 FIFO: DEPTH entries of 32 bits {l,r}, with write pointer, read pointer and occupancy count of width log2(DEPTH)+1; full = (count==DEPTH), empty = (count==0).
REQ-015 Arbitration is round-robin between the two requesters with a last_grant register; at most one grant per cycle.
REQ-016 reqN_ready = reqN_valid && !full && (other requester not valid || last_grant != N); ready is combinational from the valid inputs and registered state.
REQ-017 A push occurs when reqN_valid && reqN_ready; last_grant <= N on a push and holds otherwise.
REQ-018 Full FIFO: both readies are 0 even in a cycle with a simultaneous pop; there is no full-bypass.
REQ-019 Pop on tick when !empty: audio0/audio1 <= head {l,r} in the next cycle, and the read pointer advances.
REQ-020 Tick with empty FIFO: audio0/audio1 hold their last values; this is an underrun.
REQ-021 sample_stb is registered; it pulses for exactly 1 cycle, in the cycle after every tick, whether the tick popped or underran.
REQ-022 Simultaneous push and pop: occupancy count is unchanged and both pointers advance.
REQ-023 No empty-bypass: a sample pushed in the same cycle as a tick on an empty FIFO is not output on that tick; it is output on the next tick.
REQ-024 Pointers wrap modulo DEPTH.
REQ-025 Minimum latency from push to output is 1 cycle after the first tick following the push.

Reset
REQ-026 While reset=1: divider=0, pointers=0, count=0, last_grant=1 (requester 0 wins the first contention), audio0=audio1=0, sample_stb=0, underrun_cnt=0, req0_ready=req1_ready=0.
REQ-027 Reset asserted mid-operation discards all FIFO contents and restarts the divider; the first tick after release occurs 833 cycles later at defaults.

Configuration
REQ-028 Macro HDMI_AUDIO_UNDERRUN_CNT_EN defined: underrun_cnt increments by 1 on each underrun tick and saturates at 255.
REQ-029 Macro HDMI_AUDIO_UNDERRUN_CNT_EN undefined: no counter logic is built and underrun_cnt is constant 0; all other behaviour is identical.

Verification
REQ-030 Release reset, push req0 {l=0x1234, r=0xABCD} once -> at the first tick, sample_stb=1 one cycle later, with audio0=0x1234 and audio1=0xABCD.
REQ-031 Hold req0_valid and req1_valid high from reset with a non-full FIFO -> grants occur in the order 0,1,0,1; the FIFO holds the alternating samples and is output in that order on successive ticks.
REQ-032 Fill the FIFO with 4 pushes and hold valid -> both readies are 0; at the tick, the pop occurs and readies stay 0 in the pop cycle; in the next cycle one ready=1.
REQ-033 No pushes for 3 ticks after a sample 0x0100/0x0200 -> outputs hold 0x0100/0x0200, 3 sample_stb pulses occur, underrun_cnt=3 with the macro and 0 without; 300 underruns -> underrun_cnt=255.
REQ-034 Push on an empty FIFO in the tick cycle -> outputs unchanged on that tick and underrun counted; the sample appears on the next tick, 833 cycles later.
REQ-035 Assert reset for 1 cycle with 3 entries queued -> all outputs 0, readies 0 during reset; after release the next tick is an underrun and outputs stay 0.
